// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//
// Shares one FIFO write port between NREQ requesters. An idle arbiter picks
// the next requester round-robin after the previous owner, then grants it the
// port for a burst of up to MAX_BURST accepted beats. A burst ends when the
// owner drops its request or reaches MAX_BURST beats. Every release is
// followed by at least one idle cycle before the next grant. While the FIFO
// is full, the burst stalls without a timeout.
//
// Ports
//   wclk      : clock, rising edge
//   wrst_n    : asynchronous active-low reset
//   req       : per-requester word-valid
//   req_data  : per-requester data lanes, lane i at [i*DSIZE +: DSIZE]
//   gnt       : registered one-hot ownership (all zero when idle)
//   ack       : per-requester beat accepted this cycle (combinational)
//   wfull     : FIFO full flag (wclk domain)
//   winc      : FIFO write enable (combinational)
//   wdata     : FIFO write data, always the owner's lane
//   busy      : high while a burst is in progress
//   owner     : index of the current or most recent owner
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
    parameter int DSIZE     = 8,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    localparam int OW       = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW       = $clog2(MAX_BURST + 1)
) (
    input  logic                  wclk,
    input  logic                  wrst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       ack,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  busy,
    output logic [OW-1:0]         owner
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [NREQ-1:0] gnt_d;
    logic [OW-1:0]   owner_d;
    logic [OW-1:0]   last_q;
    logic [OW-1:0]   last_d;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   beat_cnt_d;

    logic            sel_vld;
    logic [OW-1:0]   sel_idx;
    logic            accept;

    // Round-robin search: scan last+1, last+2, ... wrapping, so the previous
    // owner is considered last. The first hit wins.
    always_comb begin
        int       idx;
        logic [OW-1:0] cand;
        sel_vld = 1'b0;
        sel_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int i = 1; i <= NREQ; i++) begin
            idx  = (int'(last_q) + i) % NREQ;
            cand = OW'(idx);
            if (!sel_vld && req[cand]) begin
                sel_vld = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign busy   = (state_q == BURST);
    assign accept = busy && req[owner] && !wfull;
    assign winc   = accept;
    assign wdata  = req_data[int'(owner)*DSIZE +: DSIZE];

    always_comb begin
        ack = '0;
        if (accept) begin
            ack[owner] = 1'b1;
        end
    end

    // Next-state logic. Non-owner requests are not looked at during a burst.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt;
        owner_d    = owner;
        last_d     = last_q;
        beat_cnt_d = beat_cnt;
        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    state_d        = BURST;
                    owner_d        = sel_idx;
                    gnt_d          = '0;
                    gnt_d[sel_idx] = 1'b1;
                    beat_cnt_d     = '0;
                end
            end
            BURST: begin
                if (!req[owner]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = owner;
                end else if (accept) begin
                    beat_cnt_d = beat_cnt + CW'(1);
                    // This beat is the last one the grant allows.
                    if (beat_cnt == CW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        last_d  = owner;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    // last resets to NREQ-1 so that requester 0 is first in line after reset.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q  <= IDLE;
            gnt      <= '0;
            owner    <= '0;
            last_q   <= OW'(NREQ - 1);
            beat_cnt <= '0;
        end else begin
            state_q  <= state_d;
            gnt      <= gnt_d;
            owner    <= owner_d;
            last_q   <= last_d;
            beat_cnt <= beat_cnt_d;
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The module SHALL have parameter DSIZE, default 8, giving the data word width in bits and matching the FIFO write data width.
REQ-002 The module SHALL have parameter NREQ, default 4, giving the number of requesters sharing the FIFO write port (range 2..8).
REQ-003 The module SHALL have parameter MAX_BURST, default 4, giving the maximum number of beats accepted per grant (range 1..16).
REQ-004 Port wclk, input, 1 bit: the only clock, rising edge active.
REQ-005 Port wrst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port req, input, NREQ bits: req[i] high means requester i has a word valid on its data lane.
REQ-007 Port req_data, input, NREQ*DSIZE bits: lane i occupies bits [i*DSIZE +: DSIZE].
REQ-008 Port gnt, output, NREQ bits: registered one-hot write-port ownership, or all zero.
REQ-009 Port ack, output, NREQ bits: ack[i] high means requester i's word is written this cycle.
REQ-010 Port wfull, input, 1 bit: FIFO full flag, already in the wclk domain.
REQ-011 Port winc, output, 1 bit: FIFO write enable.
REQ-012 Port wdata, output, DSIZE bits: FIFO write data.
REQ-013 Port busy, output, 1 bit: high while in state BURST.
REQ-014 Port owner, output, clog2(NREQ) bits: index of the current or most recent owner.

Function
REQ-015 Two states SHALL exist: IDLE (no gnt bit set) and BURST (exactly one gnt bit set).
REQ-016 In IDLE with any req bit high, the arbiter SHALL select the first requester with req high, searching round-robin from (last+1) mod NREQ upward, where last is the previous owner.
REQ-017 On that selection, the next edge SHALL load owner, set gnt[owner], clear beat_cnt and enter BURST; grant latency from req to gnt is therefore 1 cycle.
REQ-018 In IDLE with no req bit high, the state SHALL remain IDLE and owner SHALL be unchanged.
REQ-019 A beat SHALL be accepted in a BURST cycle if and only if req[owner]=1 and wfull=0.
REQ-020 In an accepted-beat cycle: winc=1, ack[owner]=1, wdata=lane owner, and beat_cnt increments by 1 at the edge; all three outputs are combinational from the current state and inputs.
REQ-021 When no beat is accepted: winc=0 and ack is all zero.
REQ-022 wdata SHALL be lane owner in every cycle, so its value is don't-care when winc=0 but stable.
REQ-023 With wfull=1 and req[owner]=1, the arbiter SHALL stall: grant held, beat_cnt unchanged, no timeout.
REQ-024 With req[owner]=0 in BURST, whatever wfull is, the next edge SHALL clear gnt, set last=owner and return to IDLE.
REQ-025 When an accepted beat brings beat_cnt to MAX_BURST, the next edge SHALL clear gnt, set last=owner and return to IDLE.
REQ-026 Each grant release SHALL be followed by at least one IDLE cycle, so there are no back-to-back grants without a bubble.
REQ-027 In BURST, req of non-owners SHALL be ignored until the return to IDLE.
REQ-028 beat_cnt SHALL be clog2(MAX_BURST+1) bits wide and SHALL never exceed MAX_BURST.
REQ-029 The fairness bound SHALL hold: a continuously requesting requester is granted within NREQ-1 other grants.

Reset
REQ-030 Asserting wrst_n low SHALL immediately force: state IDLE, gnt=0, ack=0, winc=0, busy=0, owner=0, beat_cnt=0, last=NREQ-1 (so requester 0 wins first).
REQ-031 Reset asserted mid-burst SHALL drop winc in the same cycle, with no partial beat.
REQ-032 The first grant after reset release SHALL be possible on the first rising edge with wrst_n high.

Verification
REQ-033 The bench SHALL cover: req=4'b0001, wfull=0, MAX_BURST=4, with req0 held -> gnt=0001 after 1 cycle, 4 consecutive winc with lane0 data, then 1 IDLE cycle.
REQ-034 The bench SHALL cover: req=4'b1111 held -> grants in order 0,1,2,3,0, each for 4 beats, separated by 1 idle cycle.
REQ-035 The bench SHALL cover: wfull=1 for cycles 2-5 of a req2 burst -> winc=0 and gnt=0100 held throughout, beat count resumes, and exactly 4 beats total.
REQ-036 The bench SHALL cover: req1 drops after 2 beats -> gnt cleared next edge and the next search starts at requester 2.
REQ-037 The bench SHALL cover: wrst_n pulsed low mid-burst -> winc=0 and gnt=0 asynchronously, then requester 0 is first granted after release.
REQ-038 The bench SHALL cover: req3 and req0 held with last=3 -> requester 0 granted, and requester 3 granted after that burst.
